// File: rtl/pkt_wrr_arbiter.sv
// Weighted round-robin packet arbiter merging NUM_IN Avalon-ST requesters onto one stream.
// Define PKT_ARB_STATS_EN to add per-input end-of-packet counters on stat_pkt_cnt.
module pkt_wrr_arbiter #(
    parameter int NUM_IN   = 3,
    parameter int DATA_W   = 512,
    parameter int EMPTY_W  = 6,
    parameter int WEIGHT_W = 4
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic [NUM_IN*DATA_W-1:0]   in_data,
    input  logic [NUM_IN-1:0]          in_valid,
    output logic [NUM_IN-1:0]          in_ready,
    input  logic [NUM_IN-1:0]          in_startofpacket,
    input  logic [NUM_IN-1:0]          in_endofpacket,
    input  logic [NUM_IN*EMPTY_W-1:0]  in_empty,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_startofpacket,
    output logic                       out_endofpacket,
    output logic [EMPTY_W-1:0]         out_empty,
    output logic [1:0]                 out_channel,
    input  logic [NUM_IN*WEIGHT_W-1:0] cfg_weight
`ifdef PKT_ARB_STATS_EN
    ,
    output logic [NUM_IN*32-1:0]       stat_pkt_cnt
`endif
);

    localparam int IDX_W = 2;

    typedef enum logic {StIdle, StXfer} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    grant_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [WEIGHT_W-1:0] credit_q [NUM_IN];
    logic [NUM_IN-1:0]   credit_vld_q;

    logic [WEIGHT_W-1:0] reload_val [NUM_IN];
    logic [DATA_W-1:0]   lane_data  [NUM_IN];
    logic [EMPTY_W-1:0]  lane_empty [NUM_IN];
    logic                found;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    scan_idx;
    logic [NUM_IN-1:0]   skip_mask;
    logic                beat_xfer;
    logic                eop_xfer;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            reload_val[i] = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
            if (reload_val[i] == '0) begin
                reload_val[i] = WEIGHT_W'(1);
            end
            lane_data[i]  = in_data[i*DATA_W +: DATA_W];
            lane_empty[i] = in_empty[i*EMPTY_W +: EMPTY_W];
        end
    end

    // First requester at or after rr_ptr; inputs passed over lose any unused credit.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        scan_idx  = '0;
        skip_mask = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_IN);
            if (!found) begin
                if (in_valid[scan_idx]) begin
                    found = 1'b1;
                    pick  = scan_idx;
                end else begin
                    skip_mask[scan_idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready          = '0;
        out_valid         = 1'b0;
        out_data          = lane_data[grant_q];
        out_empty         = lane_empty[grant_q];
        out_startofpacket = in_startofpacket[grant_q];
        out_endofpacket   = in_endofpacket[grant_q];
        out_channel       = grant_q;
        if (state_q == StXfer) begin
            out_valid         = in_valid[grant_q];
            in_ready[grant_q] = out_ready;
        end
    end

    assign beat_xfer = out_valid & out_ready;
    assign eop_xfer  = beat_xfer & out_endofpacket;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            credit_vld_q <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                credit_q[i] <= WEIGHT_W'(1);
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        grant_q <= pick;
                        state_q <= StXfer;
                        for (int i = 0; i < NUM_IN; i++) begin
                            if (skip_mask[i]) begin
                                credit_q[i]     <= reload_val[i];
                                credit_vld_q[i] <= 1'b1;
                            end
                        end
                        // Credits left at their reset value are loaded on first grant.
                        if (!credit_vld_q[pick]) begin
                            credit_q[pick]     <= reload_val[pick];
                            credit_vld_q[pick] <= 1'b1;
                        end
                    end
                end
                StXfer: begin
                    if (eop_xfer) begin
                        state_q <= StIdle;
                        if (credit_q[grant_q] == WEIGHT_W'(1)) begin
                            credit_q[grant_q] <= reload_val[grant_q];
                            rr_ptr_q <= (grant_q == IDX_W'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;
                        end else begin
                            credit_q[grant_q] <= credit_q[grant_q] - 1'b1;
                            rr_ptr_q          <= grant_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef PKT_ARB_STATS_EN
    logic [31:0] stat_q [NUM_IN];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                stat_q[i] <= '0;
            end
        end else if (eop_xfer) begin
            stat_q[grant_q] <= stat_q[grant_q] + 32'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            stat_pkt_cnt[i*32 +: 32] = stat_q[i];
        end
    end
`endif

endmodule
